move_scheduler: RTL
===================

// Module: move_scheduler
// PURPOSE
//  Sequences every board move in the puzzle game onto one move port of the play datapath.
//  The port uses a valid/ready handshake.
//  There are two requester classes:
//   - manual: four debounced action-button flags;
//   - scramble: an internal LFSR that issues SCRAMBLE_LEN random moves on game initialisation.
//  Sits between the bottomFlag instances / fsm and the play datapath.
//  Owns the manual step count shown on the 7-segment display.
// PARAMETERS
//  SCRAMBLE_LEN  16       random moves issued per initialisation (1..255)
//  LFSR_SEED     8'hA5    LFSR reset value; must be non-zero
//  STEP_MAX      9999     step_number saturation value (fits 14 bits)
// PORTS
//  clk_d         in   1   game clock; all state changes on its rising edge
//  rst           in   1   asynchronous, active-high reset
//  game_status   in   2   00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED
//  random_sw     in   1   1 = scramble on initialisation; 0 = skip scramble
//  act_flag      in   4   one-cycle button pulses; bit i requests move code i
//  move_ready    in   1   datapath accepts move this cycle
//  move_valid    out  1   move offered; held until accepted or aborted
//  move_code     out  2   move index; stable while move_valid=1
//  move_manual   out  1   1 = offered move is manual, 0 = scramble; stable with move_code
//  scramble_done out  1   level; 1 once scramble complete for current initialisation
//  step_number   out  14  count of accepted manual moves, saturating
//  busy          out  1   move_valid | scramble in progress
// BEHAVIOUR
//  Reset values: all outputs 0; pend=0; rr_ptr=0; lfsr=LFSR_SEED; state=IDLE.
//  Transfer: a cycle with move_valid & move_ready. Only one move outstanding at a time.
//  After any transfer, move_valid is 0 for exactly 1 cycle before the next offer.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4. Free-runs every clk_d cycle from reset.
//  FSM states:
//   IDLE: entered from any state when status = 00 or 11.
//     Abort: move_valid drops the same cycle; no transfer is counted; pend cleared.
//   INIT: entered on a 00->10 or 11->10 status edge.
//     Actions: step_number<=0, scramble_done<=0, pend cleared, scramble cnt<=0.
//     Next: SCRAMBLE if random_sw=1, else DONE.
//   SCRAMBLE:
//     Offer: move_code = lfsr[1:0], sampled when the offer is raised; move_manual=0.
//     Counting: cnt increments on each transfer.
//     Exit: after transfer number SCRAMBLE_LEN, go to DONE.
//     Manual flags arriving in this state are discarded.
//   DONE: scramble_done<=1, held until the next INIT.
//     Manual flags are still discarded until status=01.
//   RUN (status=01):
//     Capture: act_flag[i] sets pend[i] the next cycle. A repeat pulse while pend[i]=1 coalesces (single move).
//     Grant: when no offer is outstanding, grant the first set pend bit searching rr_ptr, rr_ptr+1, ... mod 4.
//       On grant: move_valid<=1, move_code<=i, move_manual<=1, rr_ptr<=i+1.
//       pend[i] clears on transfer; a new act_flag[i] in that same cycle re-sets it.
//     Latency: flag at cycle t -> move_valid at t+2 when the port is idle.
//     Step count: manual transfer -> step_number+1 next cycle, saturating at STEP_MAX.
//  Other status cases:
//   - 01->10 mid-game: behaves as INIT; any offer is aborted first.
//   - status 10 held after DONE: no further moves.
//  Arithmetic: step_number and cnt are unsigned; step_number never wraps.
//  Async rst mid-handshake: move_valid drops immediately; no partial state survives.
// TESTING
//  1 Reset: rst=1 -> all outputs 0; after release, lfsr=A5; move_valid=0.
//  2 Scramble: status 00->10, random_sw=1, move_ready=1.
//    -> 16 transfers, move_manual=0, codes match LFSR model; gap cycle between each.
//    -> scramble_done=1 after the 16th transfer.
//  3 No scramble: random_sw=0, status ->10 -> scramble_done=1 within 2 cycles; move_valid never rises.
//  4 Round-robin: status=01, act_flag=4'b1111 in one cycle, move_ready=1.
//    -> codes 0,1,2,3 in order; step_number=4.
//    -> then act_flag=4'b1001 -> codes 0,3.
//  5 Backpressure and coalescing:
//    -> move_ready=0 for 10 cycles: move_code stays stable.
//    -> act_flag[2] pulses twice meanwhile: yields one move 2 only.
//  6 Saturation/abort:
//    -> preload step_number=9999 via 9999 moves: a further move keeps 9999.
//    -> status->11 during an offer: move_valid=0 next edge; step_number unchanged.

Source files
------------

// File: rtl/move_scheduler.sv
// Single-port move sequencer for the puzzle game: arbitrates the LFSR scramble and the
// four manual action buttons onto one valid/ready move port, and keeps the step count.
module move_scheduler #(
  parameter int          SCRAMBLE_LEN = 16,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5,
  parameter int          STEP_MAX     = 9999
) (
  input  logic        clk_d,
  input  logic        rst,
  input  logic [1:0]  game_status,
  input  logic        random_sw,
  input  logic [3:0]  act_flag,
  input  logic        move_ready,
  output logic        move_valid,
  output logic [1:0]  move_code,
  output logic        move_manual,
  output logic        scramble_done,
  output logic [13:0] step_number,
  output logic        busy
);

  localparam logic [1:0] ST_CHOSE  = 2'b00;
  localparam logic [1:0] ST_GAMING = 2'b01;
  localparam logic [1:0] ST_INIT   = 2'b10;
  localparam logic [1:0] ST_WIN    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SCRAMBLE,
    S_DONE,
    S_RUN
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_lfsr;
  logic [1:0]  r_status;
  logic [3:0]  r_pend;
  logic [1:0]  r_rr;
  logic [7:0]  r_cnt;
  logic        r_valid;
  logic [1:0]  r_code;
  logic        r_manual;
  logic        r_done;
  logic [13:0] r_step;

  logic        w_idle_status;
  logic        w_abort;
  logic        w_xfer;
  logic [2:0]  w_pick;
  logic [3:0]  w_clr;

  // Round-robin search starting at ptr; returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] pend, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (pend[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // Any status change or a non-playing status kills an outstanding offer in the same cycle.
  assign w_idle_status = (game_status == ST_CHOSE) || (game_status == ST_WIN);
  assign w_abort       = w_idle_status || (game_status != r_status);
  assign move_valid    = r_valid & ~w_abort;
  assign w_xfer        = move_valid & move_ready;
  assign w_pick        = rr_pick(r_pend, r_rr);
  assign w_clr         = (w_xfer && r_manual) ? (4'b0001 << r_code) : 4'b0000;

  assign move_code     = r_code;
  assign move_manual   = r_manual;
  assign scramble_done = r_done;
  assign step_number   = r_step;
  assign busy          = move_valid | (r_state == S_SCRAMBLE);

  always_comb begin
    w_next = r_state;
    if (w_idle_status) begin
      w_next = S_IDLE;
    end else if ((game_status == ST_INIT) && (r_status != ST_INIT)) begin
      w_next = S_INIT;
    end else if (game_status == ST_GAMING) begin
      w_next = S_RUN;
    end else begin
      case (r_state)
        S_INIT:     w_next = random_sw ? S_SCRAMBLE : S_DONE;
        S_SCRAMBLE: if (w_xfer && (r_cnt == 8'(SCRAMBLE_LEN - 1))) w_next = S_DONE;
        default:    w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_status <= ST_CHOSE;
      r_lfsr   <= LFSR_SEED;
      r_pend   <= 4'b0000;
      r_rr     <= 2'd0;
      r_cnt    <= 8'd0;
      r_valid  <= 1'b0;
      r_code   <= 2'd0;
      r_manual <= 1'b0;
      r_done   <= 1'b0;
      r_step   <= 14'd0;
    end else begin
      r_state  <= w_next;
      r_status <= game_status;
      r_lfsr   <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

      // Offer register: clearing after a transfer yields the mandatory one-cycle gap.
      if ((w_next == S_INIT) || (w_next == S_IDLE) || w_abort || w_xfer) begin
        r_valid <= 1'b0;
      end else if (!r_valid) begin
        if ((r_state == S_SCRAMBLE) && (w_next == S_SCRAMBLE)) begin
          r_valid  <= 1'b1;
          r_code   <= r_lfsr[1:0];
          r_manual <= 1'b0;
        end else if ((r_state == S_RUN) && (w_next == S_RUN) && w_pick[2]) begin
          r_valid  <= 1'b1;
          r_code   <= w_pick[1:0];
          r_manual <= 1'b1;
          r_rr     <= w_pick[1:0] + 2'd1;
        end
      end

      if (w_next == S_RUN) r_pend <= (r_pend & ~w_clr) | act_flag;
      else                 r_pend <= 4'b0000;

      if (w_next == S_INIT)                      r_cnt <= 8'd0;
      else if ((r_state == S_SCRAMBLE) && w_xfer) r_cnt <= r_cnt + 8'd1;

      if (w_next == S_INIT)      r_done <= 1'b0;
      else if (w_next == S_DONE) r_done <= 1'b1;

      if (w_next == S_INIT)
        r_step <= 14'd0;
      else if (w_xfer && r_manual && (r_step != 14'(STEP_MAX)))
        r_step <= r_step + 14'd1;
    end
  end

endmodule
